pma_region_unit: RTL and testbench
==================================

Name: pma_region_unit

Overview:
Runtime-programmable physical-memory-attribute unit. It replaces fixed compile-time non-idempotent, execute and cached region tables with NrRegions software-writable rules. It sits beside the MMU/PMP path. Each rule is programmed through a simple register port, and each lookup request returns the matching attributes through a one-stage valid/ready pipeline.

Parameters:
NrRegions, 8, number of region rules (1..16)
AddrWidth, 64, physical address, base and length width
DefCached, 0, cached attribute returned on a miss
DefExec, 0, execute attribute returned on a miss
DefNonIdem, 1, non-idempotent attribute returned on a miss

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_req_i  in  1  config access strobe
cfg_we_i  in  1  1 = write, 0 = read
cfg_addr_i  in  $clog2(NrRegions)+2  {region index, field}; field 0 = base, 1 = length, 2 = attr, 3 = reserved
cfg_wdata_i  in  AddrWidth  write data
cfg_rvalid_o  out  1  access response valid, one cycle after cfg_req_i
cfg_rdata_o  out  AddrWidth  read data
cfg_err_o  out  1  error, qualified by cfg_rvalid_o
lookup_valid_i  in  1  lookup request valid
lookup_addr_i  in  AddrWidth  physical address to check
lookup_ready_o  out  1  lookup request ready
result_valid_o  out  1  result valid
result_ready_i  in  1  result consumed
result_hit_o  out  1  address matched an enabled region
result_idx_o  out  $clog2(NrRegions)  index of the matching region
result_cached_o  out  1  cached attribute
result_exec_o  out  1  execute attribute
result_nonidem_o  out  1  non-idempotent attribute
result_fault_o  out  1  miss fault (see Optional Feature)

Behaviour:
- Per-region state:
  - base[AddrWidth], len[AddrWidth]
  - attr[4:0] = {lock, nonidem, exec, cached, enable}; bits [AddrWidth-1:5] read as 0.
- Reset: all region state is 0 (every region disabled and unlocked). All outputs are 0.
- Config port:
  - Always accepted. cfg_rvalid_o pulses exactly one cycle after each cfg_req_i.
  - A write updates the field at the clock edge where the request is sampled.
  - Error cases (write ignored, cfg_err_o = 1):
    - write to a region whose lock bit is 1, covering all fields including attr;
    - write or read to field 3;
    - write or read to an index >= NrRegions.
  - An erroring read returns 0.
  - A write that sets lock takes effect together with the other bits in the same write. The lock clears only on reset.
- Match rule: region i matches when enable = 1, len != 0, and base <= addr < base + len.
  - The sum is computed at AddrWidth+1 bits, so a region ending exactly at 2^AddrWidth is legal and does not wrap.
  - The lowest matching index wins.
- On a miss: hit = 0, idx = 0, attributes = DefCached / DefExec / DefNonIdem.
- Lookup pipeline (one stage):
  - lookup_ready_o = !result_valid_o || result_ready_i.
  - On a lookup_valid_i && lookup_ready_o handshake, match logic evaluated on the current (pre-edge) region state is registered. result_valid_o rises the next cycle, giving 1-cycle latency.
  - Full throughput: back-to-back lookups are accepted every cycle while result_ready_i = 1.
  - Stall: while result_valid_o && !result_ready_i, all result outputs hold stable.
  - If a result is consumed with no new handshake, result_valid_o falls.
- Simultaneous config write and lookup handshake: the lookup sees the old values; the next lookup sees the new ones.
- Reset mid-operation: an in-flight result is discarded and all region state is cleared.

Optional Feature:
PMA_MISS_FAULT_EN
- Defined: result_fault_o = !result_hit_o whenever result_valid_o = 1. Default attributes are still driven on a miss.
- Undefined: result_fault_o is tied to 0 and misses rely on the Def* parameters only.

Test Plan:
- Reset, then read region 0 attr and look up 0x8000_0000 -> cfg_rdata_o = 0; result_hit_o = 0, cached = 0, exec = 0, nonidem = 1 (defaults).
- Program region 2 with base 0x8000_0000, len 0x4000_0000, attr 0x07. Look up 0x8000_0000, 0xBFFF_FFFF and 0xC000_0000 -> hit/idx 2/cached 1/exec 1, hit/idx 2, then miss.
- Overlap: region 1 with base 0x8000_0000, len 0x1000, attr 0x09; region 2 as above. Look up 0x8000_0800 -> idx 1, nonidem 1, cached 0.
- Lock: write attr 0x11 to region 3, then write base -> second access returns cfg_err_o = 1 and a readback shows base unchanged. Write to field 3 -> cfg_err_o = 1.
- Backpressure: hold result_ready_i = 0 for 3 cycles during back-to-back lookups -> lookup_ready_o = 0 and outputs stable. Release -> one result per cycle with no loss or duplication.
- Top region: base 0xFFFF_FFFF_FFFF_F000, len 0x1000 -> lookup of 0xFFFF_FFFF_FFFF_FFFF hits. With PMA_MISS_FAULT_EN defined, a miss asserts result_fault_o = 1.

Source files
------------

// File: rtl/pma_region_unit_if.sv
// Bus bundle for pma_region_unit: the config register port plus the lookup
// request/result handshake. The requester takes the master side and the unit takes the slave side.
interface pma_region_unit_if #(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64
);
    localparam int unsigned IdxWidth     = (NrRegions > 1) ? $clog2(NrRegions) : 1;
    localparam int unsigned CfgAddrWidth = $clog2(NrRegions) + 2;

    logic                    cfg_req;
    logic                    cfg_we;
    logic [CfgAddrWidth-1:0] cfg_addr;
    logic [AddrWidth-1:0]    cfg_wdata;
    logic                    cfg_rvalid;
    logic [AddrWidth-1:0]    cfg_rdata;
    logic                    cfg_err;

    logic                    lookup_valid;
    logic [AddrWidth-1:0]    lookup_addr;
    logic                    lookup_ready;

    logic                    result_valid;
    logic                    result_ready;
    logic                    result_hit;
    logic [IdxWidth-1:0]     result_idx;
    logic                    result_cached;
    logic                    result_exec;
    logic                    result_nonidem;
    logic                    result_fault;

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output lookup_valid, lookup_addr, result_ready,
        input  cfg_rvalid, cfg_rdata, cfg_err, lookup_ready,
        input  result_valid, result_hit, result_idx,
        input  result_cached, result_exec, result_nonidem, result_fault
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  lookup_valid, lookup_addr, result_ready,
        output cfg_rvalid, cfg_rdata, cfg_err, lookup_ready,
        output result_valid, result_hit, result_idx,
        output result_cached, result_exec, result_nonidem, result_fault
    );
endinterface

// File: rtl/pma_region_unit.sv
// Runtime-programmable PMA unit: NrRegions base/len/attr rules, a register config port, and a one-stage lookup pipeline.
// Optional: define PMA_MISS_FAULT_EN to flag lookups that match no region on result_fault.
module pma_region_unit #(
    parameter int unsigned NrRegions  = 8,
    parameter int unsigned AddrWidth  = 64,
    parameter bit          DefCached  = 1'b0,
    parameter bit          DefExec    = 1'b0,
    parameter bit          DefNonIdem = 1'b1
) (
    input logic              clk_i,
    input logic              rst_ni,
    pma_region_unit_if.slave bus
);
    localparam int unsigned IdxWidth     = (NrRegions > 1) ? $clog2(NrRegions) : 1;
    localparam int unsigned CfgIdxBits   = $clog2(NrRegions);
    localparam int unsigned CfgAddrWidth = CfgIdxBits + 2;

    typedef enum logic [1:0] {
        FieldBase = 2'd0,
        FieldLen  = 2'd1,
        FieldAttr = 2'd2,
        FieldRsvd = 2'd3
    } field_e;

    // attr bits: {lock, nonidem, exec, cached, enable}
    logic [AddrWidth-1:0] base_q [NrRegions];
    logic [AddrWidth-1:0] len_q  [NrRegions];
    logic [4:0]           attr_q [NrRegions];

    logic                 cfg_rvalid_q;
    logic                 cfg_err_q;
    logic [AddrWidth-1:0] cfg_rdata_q;

    logic [IdxWidth-1:0]  cfg_idx;
    field_e               cfg_field;
    logic                 cfg_idx_ok;
    logic                 cfg_err;
    logic [AddrWidth-1:0] cfg_rdata;

    logic                 match_hit;
    logic [IdxWidth-1:0]  match_idx;
    logic                 match_cached;
    logic                 match_exec;
    logic                 match_nonidem;

    logic                 result_valid_q;
    logic                 result_hit_q;
    logic [IdxWidth-1:0]  result_idx_q;
    logic                 result_cached_q;
    logic                 result_exec_q;
    logic                 result_nonidem_q;

    assign cfg_field = field_e'(bus.cfg_addr[1:0]);

    generate
        if (CfgIdxBits > 0) begin : g_cfg_idx
            assign cfg_idx = bus.cfg_addr[CfgAddrWidth-1:2];
        end else begin : g_cfg_no_idx
            assign cfg_idx = '0;
        end
    endgenerate

    // The extra top bit keeps the range check meaningful when NrRegions is a power of two.
    assign cfg_idx_ok = ({1'b0, cfg_idx} < (IdxWidth+1)'(NrRegions));

    always_comb begin
        cfg_rdata = '0;
        cfg_err   = 1'b0;
        if (!cfg_idx_ok || cfg_field == FieldRsvd) begin
            cfg_err = 1'b1;
        end else if (bus.cfg_we) begin
            cfg_err = attr_q[cfg_idx][4];
        end else begin
            case (cfg_field)
                FieldBase: cfg_rdata = base_q[cfg_idx];
                FieldLen:  cfg_rdata = len_q[cfg_idx];
                FieldAttr: cfg_rdata = {{(AddrWidth-5){1'b0}}, attr_q[cfg_idx]};
                FieldRsvd: cfg_rdata = '0;
            endcase
        end
    end

    // A write that sets lock lands together with its other attr bits; only reset clears lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                attr_q[i] <= '0;
            end
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            cfg_rvalid_q <= bus.cfg_req;
            cfg_err_q    <= bus.cfg_req & cfg_err;
            cfg_rdata_q  <= bus.cfg_req ? cfg_rdata : '0;
            if (bus.cfg_req && bus.cfg_we && !cfg_err) begin
                case (cfg_field)
                    FieldBase: base_q[cfg_idx] <= bus.cfg_wdata;
                    FieldLen:  len_q[cfg_idx]  <= bus.cfg_wdata;
                    FieldAttr: attr_q[cfg_idx] <= bus.cfg_wdata[4:0];
                    FieldRsvd: ;
                endcase
            end
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    // The end address is formed one bit wider so a region ending at 2^AddrWidth does not wrap.
    always_comb begin
        match_hit     = 1'b0;
        match_idx     = '0;
        match_cached  = DefCached;
        match_exec    = DefExec;
        match_nonidem = DefNonIdem;
        for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
            if (attr_q[i][0] && (len_q[i] != '0) &&
                (bus.lookup_addr >= base_q[i]) &&
                ({1'b0, bus.lookup_addr} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}))) begin
                match_hit     = 1'b1;
                match_idx     = IdxWidth'(i);
                match_cached  = attr_q[i][1];
                match_exec    = attr_q[i][2];
                match_nonidem = attr_q[i][3];
            end
        end
    end

    assign bus.lookup_ready = !result_valid_q || bus.result_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_q   <= 1'b0;
            result_hit_q     <= 1'b0;
            result_idx_q     <= '0;
            result_cached_q  <= 1'b0;
            result_exec_q    <= 1'b0;
            result_nonidem_q <= 1'b0;
        end else if (bus.lookup_ready) begin
            result_valid_q <= bus.lookup_valid;
            if (bus.lookup_valid) begin
                result_hit_q     <= match_hit;
                result_idx_q     <= match_idx;
                result_cached_q  <= match_cached;
                result_exec_q    <= match_exec;
                result_nonidem_q <= match_nonidem;
            end
        end
    end

    assign bus.cfg_rvalid     = cfg_rvalid_q;
    assign bus.cfg_err        = cfg_err_q;
    assign bus.cfg_rdata      = cfg_rdata_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result_hit     = result_hit_q;
    assign bus.result_idx     = result_idx_q;
    assign bus.result_cached  = result_cached_q;
    assign bus.result_exec    = result_exec_q;
    assign bus.result_nonidem = result_nonidem_q;

`ifdef PMA_MISS_FAULT_EN
    assign bus.result_fault = result_valid_q && !result_hit_q;
`else
    assign bus.result_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pma_region_unit.sv
// Directed bench for pma_region_unit: config port, region matching, locking, backpressure and reset.
// Fault expectations follow PMA_MISS_FAULT_EN when it is defined for the build.
module tb_pma_region_unit;
    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;

    pma_region_unit_if #(.NrRegions(8), .AddrWidth(64)) bus ();

    pma_region_unit #(.NrRegions(8), .AddrWidth(64)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One config access; response fields are captured just after the sampling edge.
    task automatic applyStimulus(input logic we, input logic [2:0] idx, input logic [1:0] field,
                                 input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
        @(negedge clk_i);
        bus.cfg_req   = 1'b1;
        bus.cfg_we    = we;
        bus.cfg_addr  = {idx, field};
        bus.cfg_wdata = wdata;
        @(posedge clk_i);
        #1;
        bus.cfg_req = 1'b0;
        bus.cfg_we  = 1'b0;
        checkOutput("cfg_rvalid", bus.cfg_rvalid, 1'b1);
        rdata = bus.cfg_rdata;
        err   = bus.cfg_err;
    endtask

    task automatic lookupAddr(input logic [63:0] addr);
        @(negedge clk_i);
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = addr;
        bus.result_ready = 1'b1;
        @(posedge clk_i);
        #1;
        bus.lookup_valid = 1'b0;
        checkOutput("lk_valid", bus.result_valid, 1'b1);
    endtask

    task automatic checkLookup(input string tag, input logic hit, input logic [2:0] idx,
                               input logic cached, input logic exec, input logic nonidem);
        logic exp_fault;
`ifdef PMA_MISS_FAULT_EN
        exp_fault = !hit;
`else
        exp_fault = 1'b0;
`endif
        checkOutput({tag, "_hit"},     bus.result_hit,     hit);
        checkOutput({tag, "_idx"},     bus.result_idx,     idx);
        checkOutput({tag, "_cached"},  bus.result_cached,  cached);
        checkOutput({tag, "_exec"},    bus.result_exec,    exec);
        checkOutput({tag, "_nonidem"}, bus.result_nonidem, nonidem);
        checkOutput({tag, "_fault"},   bus.result_fault,   exp_fault);
    endtask

    logic [63:0] rd;
    logic        er;
    logic [63:0] bp_addr [5];
    logic        bp_hit  [5];
    logic [2:0]  bp_idx  [5];
    int          sent;
    int          recv;
    logic        fire_lookup;
    logic        held;
    logic        held_hit;
    logic [2:0]  held_idx;

    initial begin
        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        bus.cfg_req = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_wdata = '0;
        bus.lookup_valid = 1'b0;
        bus.lookup_addr = '0;
        bus.result_ready = 1'b1;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_result_valid", bus.result_valid, 1'b0);
        checkOutput("rst_cfg_rvalid", bus.cfg_rvalid, 1'b0);
        checkOutput("rst_nonidem", bus.result_nonidem, 1'b0);
        checkOutput("rst_cfg_err", bus.cfg_err, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Empty table: readback zero, lookups take the defaults
        applyStimulus(1'b0, 3'd0, 2'd2, 64'h0, rd, er);
        checkOutput("r0_attr", rd, 64'h0);
        checkOutput("r0_attr_err", er, 1'b0);
        lookupAddr(64'h8000_0000);
        checkLookup("empty", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Region 2: [0x8000_0000, 0xC000_0000) cached+exec
        applyStimulus(1'b1, 3'd2, 2'd0, 64'h8000_0000, rd, er);
        checkOutput("r2_base_err", er, 1'b0);
        applyStimulus(1'b1, 3'd2, 2'd1, 64'h4000_0000, rd, er);
        applyStimulus(1'b1, 3'd2, 2'd2, 64'h07, rd, er);
        applyStimulus(1'b0, 3'd2, 2'd1, 64'h0, rd, er);
        checkOutput("r2_len_rd", rd, 64'h4000_0000);
        lookupAddr(64'h8000_0000);
        checkLookup("r2_lo", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        lookupAddr(64'hBFFF_FFFF);
        checkLookup("r2_hi", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        lookupAddr(64'hC000_0000);
        checkLookup("r2_end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Region 1 overlaps the bottom of region 2 and wins by lower index
        applyStimulus(1'b1, 3'd1, 2'd0, 64'h8000_0000, rd, er);
        applyStimulus(1'b1, 3'd1, 2'd1, 64'h1000, rd, er);
        applyStimulus(1'b1, 3'd1, 2'd2, 64'h09, rd, er);
        lookupAddr(64'h8000_0800);
        checkLookup("ovl_in", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        lookupAddr(64'h8000_1000);
        checkLookup("ovl_out", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);

        // Disabled region and zero-length region never match
        applyStimulus(1'b1, 3'd4, 2'd0, 64'h1000, rd, er);
        applyStimulus(1'b1, 3'd4, 2'd1, 64'h1000, rd, er);
        applyStimulus(1'b1, 3'd4, 2'd2, 64'h06, rd, er);
        lookupAddr(64'h1800);
        checkLookup("disabled", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd5, 2'd0, 64'h2000, rd, er);
        applyStimulus(1'b1, 3'd5, 2'd2, 64'h03, rd, er);
        lookupAddr(64'h2000);
        checkLookup("zero_len", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Lock: region 3 rejects further writes to any field
        applyStimulus(1'b1, 3'd3, 2'd2, 64'h11, rd, er);
        checkOutput("lock_set_err", er, 1'b0);
        applyStimulus(1'b1, 3'd3, 2'd0, 64'h1234, rd, er);
        checkOutput("lock_base_err", er, 1'b1);
        applyStimulus(1'b0, 3'd3, 2'd0, 64'h0, rd, er);
        checkOutput("lock_base_rd", rd, 64'h0);
        checkOutput("lock_base_rd_err", er, 1'b0);
        applyStimulus(1'b1, 3'd3, 2'd2, 64'h00, rd, er);
        checkOutput("lock_attr_err", er, 1'b1);
        applyStimulus(1'b0, 3'd3, 2'd2, 64'h0, rd, er);
        checkOutput("lock_attr_rd", rd, 64'h11);
        applyStimulus(1'b1, 3'd0, 2'd3, 64'hFF, rd, er);
        checkOutput("rsvd_wr_err", er, 1'b1);
        applyStimulus(1'b0, 3'd2, 2'd3, 64'h0, rd, er);
        checkOutput("rsvd_rd_err", er, 1'b1);
        checkOutput("rsvd_rd_data", rd, 64'h0);

        // Region 6 ends exactly at 2^64; address 0 must not wrap into it
        applyStimulus(1'b1, 3'd6, 2'd0, 64'hFFFF_FFFF_FFFF_F000, rd, er);
        applyStimulus(1'b1, 3'd6, 2'd1, 64'h1000, rd, er);
        applyStimulus(1'b1, 3'd6, 2'd2, 64'h03, rd, er);
        lookupAddr(64'hFFFF_FFFF_FFFF_FFFF);
        checkLookup("top_last", 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        lookupAddr(64'hFFFF_FFFF_FFFF_EFFF);
        checkLookup("top_below", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        lookupAddr(64'h0);
        checkLookup("top_nowrap", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Same-cycle write and lookup: lookup sees the old attr, the next one the new
        @(negedge clk_i);
        bus.cfg_req = 1'b1;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = {3'd4, 2'd2};
        bus.cfg_wdata = 64'h07;
        bus.lookup_valid = 1'b1;
        bus.lookup_addr = 64'h1800;
        @(posedge clk_i);
        #1;
        bus.cfg_req = 1'b0;
        bus.cfg_we = 1'b0;
        bus.lookup_valid = 1'b0;
        checkOutput("same_cyc_err", bus.cfg_err, 1'b0);
        checkLookup("same_cyc_old", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        lookupAddr(64'h1800);
        checkLookup("same_cyc_new", 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);

        // Back-to-back lookups with result_ready low for three cycles
        bp_addr[0] = 64'h8000_0800;          bp_hit[0] = 1'b1; bp_idx[0] = 3'd1;
        bp_addr[1] = 64'h8000_2000;          bp_hit[1] = 1'b1; bp_idx[1] = 3'd2;
        bp_addr[2] = 64'hFFFF_FFFF_FFFF_FFFF; bp_hit[2] = 1'b1; bp_idx[2] = 3'd6;
        bp_addr[3] = 64'h1800;               bp_hit[3] = 1'b1; bp_idx[3] = 3'd4;
        bp_addr[4] = 64'hC000_0000;          bp_hit[4] = 1'b0; bp_idx[4] = 3'd0;
        @(negedge clk_i);
        bus.result_ready = 1'b1;
        @(posedge clk_i);
        sent = 0;
        recv = 0;
        held = 1'b0;
        held_hit = 1'b0;
        held_idx = '0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            @(negedge clk_i);
            bus.lookup_valid = (sent < 5);
            bus.lookup_addr  = bp_addr[(sent < 5) ? sent : 0];
            bus.result_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            fire_lookup = bus.lookup_valid && bus.lookup_ready;
            if (bus.result_valid && bus.result_ready) begin
                checkOutput("bp_hit", bus.result_hit, bp_hit[recv]);
                checkOutput("bp_idx", bus.result_idx, bp_idx[recv]);
                recv++;
            end
            if (bus.result_valid && !bus.result_ready) begin
                checkOutput("bp_lookup_ready", bus.lookup_ready, 1'b0);
                if (held) begin
                    checkOutput("bp_hold_hit", bus.result_hit, held_hit);
                    checkOutput("bp_hold_idx", bus.result_idx, held_idx);
                end
                held = 1'b1;
                held_hit = bus.result_hit;
                held_idx = bus.result_idx;
            end else begin
                held = 1'b0;
            end
            @(posedge clk_i);
            if (fire_lookup) sent++;
        end
        @(negedge clk_i);
        bus.lookup_valid = 1'b0;
        bus.result_ready = 1'b1;
        checkOutput("bp_count", recv, 5);
        @(posedge clk_i);
        #1;
        checkOutput("bp_drained", bus.result_valid, 1'b0);

        // Reset with a result in flight clears it and all region state
        lookupAddr(64'h8000_0000);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_valid", bus.result_valid, 1'b0);
        checkOutput("midrst_hit", bus.result_hit, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 3'd2, 2'd0, 64'h0, rd, er);
        checkOutput("midrst_r2_base", rd, 64'h0);
        applyStimulus(1'b0, 3'd3, 2'd2, 64'h0, rd, er);
        checkOutput("midrst_r3_attr", rd, 64'h0);
        applyStimulus(1'b1, 3'd3, 2'd0, 64'h55, rd, er);
        checkOutput("midrst_unlock_err", er, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
